flag_branch_unit: RTL and testbench

Execute-side flag register and branch-resolution block for the 16-bit WISC pipeline; sits directly downstream of the ALU. It captures the ALU `Flags` {Z,V,N} per opcode-specific write rules and evaluates the 3-bit branch condition for a B/BR instruction in ID. When the instruction in EX is about to write flags, it stalls ID one cycle so the branch reads settled flags. It also keeps saturating branch statistics counters.

---
 rtl/wisc_pkg.sv | 52 +++++
 rtl/flag_branch_unit_if.sv | 27 ++
 rtl/br_cond_eval.sv | 30 +++
 rtl/flag_branch_unit.sv | 110 +++++++++++
 tb/tb_flag_branch_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/wisc_pkg.sv
// Shared WISC execute-side types: opcodes, branch condition codes, flag bit
// positions and the opcode-to-flag-write classification.
package wisc_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_XOR    = 4'd2,
    OP_RED    = 4'd3,
    OP_SLL    = 4'd4,
    OP_SRA    = 4'd5,
    OP_ROR    = 4'd6,
    OP_PADDSB = 4'd7,
    OP_LW     = 4'd8,
    OP_SW     = 4'd9,
    OP_LHB    = 4'd10,
    OP_LLB    = 4'd11,
    OP_B      = 4'd12,
    OP_BR     = 4'd13,
    OP_PCS    = 4'd14,
    OP_HLT    = 4'd15
  } opcode_t;

  typedef enum logic [2:0] {
    CCC_NE     = 3'd0,
    CCC_EQ     = 3'd1,
    CCC_GT     = 3'd2,
    CCC_LT     = 3'd3,
    CCC_GTE    = 3'd4,
    CCC_LTE    = 3'd5,
    CCC_OVFL   = 3'd6,
    CCC_UNCOND = 3'd7
  } ccc_t;

  typedef enum logic {
    ST_EVAL = 1'b0,
    ST_HOLD = 1'b1
  } br_state_t;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  function automatic logic writes_all_flags(opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic writes_z_only(opcode_t op);
    return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// EX/ID-side signal bundle of the flag/branch unit; the pipeline is the
// master, the unit is the slave.
interface flag_branch_unit_if;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [2:0]  alu_flags;
  logic        pipe_stall;
  logic        id_branch;
  logic [2:0]  id_ccc;
  logic        cnt_clr;
  logic [2:0]  flags;
  logic        br_stall;
  logic        br_resolved;
  logic        br_taken;
  logic [15:0] taken_cnt;
  logic [15:0] stall_cnt;

  modport master (
    output ex_valid, ex_opcode, alu_flags, pipe_stall, id_branch, id_ccc, cnt_clr,
    input  flags, br_stall, br_resolved, br_taken, taken_cnt, stall_cnt
  );

  modport slave (
    input  ex_valid, ex_opcode, alu_flags, pipe_stall, id_branch, id_ccc, cnt_clr,
    output flags, br_stall, br_resolved, br_taken, taken_cnt, stall_cnt
  );
endinterface

// File: rtl/br_cond_eval.sv
// Combinational evaluation of a 3-bit branch condition against {Z,V,N}.
module br_cond_eval
  import wisc_pkg::*;
(
  input  ccc_t       ccc,
  input  logic [2:0] flags,
  output logic       taken
);

  logic z, v, n;
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  always_comb begin
    taken = 1'b0;
    case (ccc)
      CCC_NE:     taken = !z;
      CCC_EQ:     taken = z;
      CCC_GT:     taken = !z && !n;
      CCC_LT:     taken = n;
      CCC_GTE:    taken = z || (!z && !n);
      CCC_LTE:    taken = n || z;
      CCC_OVFL:   taken = v;
      CCC_UNCOND: taken = 1'b1;
      default:    taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register, branch-resolution FSM (EVAL/HOLD) and saturating branch
// statistics for the WISC execute stage.
module flag_branch_unit
  import wisc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  flag_branch_unit_if.slave bus
);

  br_state_t   state_q, state_d;
  logic [2:0]  flags_q, flags_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  opcode_t ex_op;
  ccc_t    id_ccc;
  logic    wr_all, wr_z, flag_wr, hazard, cond_taken;
  logic    br_stall, br_resolved, br_taken;

  assign ex_op   = opcode_t'(bus.ex_opcode);
  assign id_ccc  = ccc_t'(bus.id_ccc);
  assign wr_all  = bus.ex_valid && !bus.pipe_stall && writes_all_flags(ex_op);
  assign wr_z    = bus.ex_valid && !bus.pipe_stall && writes_z_only(ex_op);
  assign flag_wr = wr_all || wr_z;
  assign hazard  = bus.id_branch && (id_ccc != CCC_UNCOND) && flag_wr;

  // The branch always looks at the registered flags, never the ALU output.
  br_cond_eval u_cond (
    .ccc   (id_ccc),
    .flags (flags_q),
    .taken (cond_taken)
  );

  always_comb begin
    flags_d = flags_q;
    if (wr_all) begin
      flags_d = bus.alu_flags;
    end else if (wr_z) begin
      flags_d[FLAG_Z] = bus.alu_flags[FLAG_Z];
    end
  end

  always_comb begin
    br_stall    = 1'b0;
    br_resolved = 1'b0;
    br_taken    = 1'b0;
    state_d     = state_q;
    if (rst_n && !bus.pipe_stall) begin
      case (state_q)
        ST_EVAL: begin
          if (hazard) begin
            br_stall = 1'b1;
            state_d  = ST_HOLD;
          end else if (bus.id_branch) begin
            br_resolved = 1'b1;
            br_taken    = cond_taken;
          end
        end
        ST_HOLD: begin
          // EX now carries the bubble from the stall, so HOLD never re-stalls.
          if (bus.id_branch) begin
            br_resolved = 1'b1;
            br_taken    = cond_taken;
          end
          state_d = ST_EVAL;
        end
        default: state_d = ST_EVAL;
      endcase
    end
  end

  always_comb begin
    taken_cnt_d = taken_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.cnt_clr) begin
      taken_cnt_d = 16'h0000;
      stall_cnt_d = 16'h0000;
    end else begin
      if (br_resolved && br_taken && (taken_cnt_q != 16'hFFFF)) begin
        taken_cnt_d = taken_cnt_q + 16'd1;
      end
      if (br_stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EVAL;
      flags_q     <= 3'b000;
      taken_cnt_q <= 16'h0000;
      stall_cnt_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      taken_cnt_q <= taken_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.flags       = flags_q;
  assign bus.br_stall    = br_stall;
  assign bus.br_resolved = br_resolved;
  assign bus.br_taken    = br_taken;
  assign bus.taken_cnt   = taken_cnt_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Randomized and directed bench for flag_branch_unit against a cycle-level
// behavioural model of the flag rules, branch conditions and counters.
module tb_flag_branch_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  flag_branch_unit_if bus ();

  flag_branch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  bit [2:0] m_flags;
  bit       m_waiting;
  int       m_taken;
  int       m_stalls;

  // Outputs captured at the last sampled cycle
  bit obs_stall, obs_res, obs_taken;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit cond_ok(input int ccc, input bit [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (ccc)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // Evaluate one cycle at the falling edge, optionally compare, then advance
  // the model to the next rising edge.
  task automatic step(input bit do_chk);
    bit e_stall, e_res, e_taken, wall, wz, fw;
    int op;
    @(negedge clk);
    op   = int'(bus.ex_opcode);
    wall = bus.ex_valid && (op == 0 || op == 1);
    wz   = bus.ex_valid && (op == 2 || op == 4 || op == 5 || op == 6);
    fw   = !bus.pipe_stall && (wall || wz);
    e_stall = 0; e_res = 0; e_taken = 0;
    if (rst_n && !bus.pipe_stall && bus.id_branch) begin
      if (!m_waiting && bus.id_ccc != 3'd7 && fw) begin
        e_stall = 1;
      end else begin
        e_res   = 1;
        e_taken = cond_ok(int'(bus.id_ccc), m_flags);
      end
    end
    obs_stall = bus.br_stall;
    obs_res   = bus.br_resolved;
    obs_taken = bus.br_taken;
    if (do_chk) begin
      chk("flags",       32'(bus.flags),       32'(m_flags));
      chk("br_stall",    32'(bus.br_stall),    32'(e_stall));
      chk("br_resolved", 32'(bus.br_resolved), 32'(e_res));
      chk("br_taken",    32'(bus.br_taken),    32'(e_taken));
      chk("taken_cnt",   32'(bus.taken_cnt),   32'(m_taken));
      chk("stall_cnt",   32'(bus.stall_cnt),   32'(m_stalls));
    end
    if (!rst_n) begin
      m_flags = 3'b000; m_waiting = 0; m_taken = 0; m_stalls = 0;
    end else begin
      if (bus.cnt_clr) begin
        m_taken = 0; m_stalls = 0;
      end else begin
        if (e_res && e_taken && m_taken < 65535) m_taken++;
        if (e_stall && m_stalls < 65535) m_stalls++;
      end
      if (fw) begin
        if (wall) m_flags = bus.alu_flags;
        else      m_flags[2] = bus.alu_flags[2];
      end
      if (!bus.pipe_stall) m_waiting = e_stall;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int op, input bit [2:0] af,
                       input bit br, input int ccc);
    bus.ex_valid  = v;
    bus.ex_opcode = 4'(op);
    bus.alu_flags = af;
    bus.id_branch = br;
    bus.id_ccc    = 3'(ccc);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.pipe_stall = 1'b0;
    bus.cnt_clr    = 1'b0;
    drive(0, 8, 3'b000, 0, 0);
    m_flags = 0; m_waiting = 0; m_taken = 0; m_stalls = 0;

    // Reset
    step(0);
    step(1);
    chk("rst_flags", 32'(bus.flags), 32'd0);
    chk("rst_tcnt",  32'(bus.taken_cnt), 32'd0);
    chk("rst_scnt",  32'(bus.stall_cnt), 32'd0);
    rst_n = 1'b1;

    // ADD hazard on an EQ branch
    drive(1, 0, 3'b100, 1, 1);
    step(1);
    chk("hz_stall", 32'(obs_stall), 32'd1);
    chk("hz_res0",  32'(obs_res),   32'd0);
    drive(0, 8, 3'b000, 1, 1);
    step(1);
    chk("hz_res",   32'(obs_res),   32'd1);
    chk("hz_taken", 32'(obs_taken), 32'd1);
    chk("hz_scnt",  32'(bus.stall_cnt), 32'd1);
    chk("hz_tcnt",  32'(bus.taken_cnt), 32'd1);

    // Partial writes
    drive(1, 0, 3'b110, 0, 0);
    step(1);
    chk("pw_setup", 32'(bus.flags), 32'b110);
    drive(1, 2, 3'b001, 0, 0);
    step(1);
    chk("pw_xor", 32'(bus.flags), 32'b010);
    drive(1, 3, 3'b111, 0, 0);
    step(1);
    chk("pw_red", 32'(bus.flags), 32'b010);

    // No-stall resolutions
    drive(1, 7, 3'b101, 1, 2);
    step(1);
    chk("ns_gt_stall", 32'(obs_stall), 32'd0);
    chk("ns_gt_taken", 32'(obs_taken), 32'd1);
    drive(1, 1, 3'b000, 1, 7);
    step(1);
    chk("ns_unc_stall", 32'(obs_stall), 32'd0);
    chk("ns_unc_taken", 32'(obs_taken), 32'd1);
    chk("ns_unc_old",   32'(bus.flags), 32'b000);

    // Freeze while in HOLD
    drive(1, 0, 3'b001, 1, 3);
    step(1);
    chk("fz_stall", 32'(obs_stall), 32'd1);
    bus.pipe_stall = 1'b1;
    drive(1, 0, 3'b100, 1, 3);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("fz_res", 32'(obs_res), 32'd0);
      chk("fz_flags", 32'(bus.flags), 32'b001);
    end
    bus.pipe_stall = 1'b0;
    drive(0, 8, 3'b000, 1, 3);
    step(1);
    chk("fz_after_res",   32'(obs_res),   32'd1);
    chk("fz_after_taken", 32'(obs_taken), 32'd1);

    // Reset abandons a pending HOLD
    drive(1, 1, 3'b100, 1, 0);
    step(1);
    rst_n = 1'b0;
    drive(0, 8, 3'b000, 1, 0);
    step(1);
    chk("rh_res", 32'(obs_res), 32'd0);
    rst_n = 1'b1;
    drive(1, 0, 3'b000, 1, 0);
    step(1);
    chk("rh_restall", 32'(obs_stall), 32'd1);
    drive(0, 8, 3'b000, 0, 0);
    step(1);

    // Counter saturation and clear priority
    drive(0, 8, 3'b000, 1, 7);
    for (int i = 0; i < 65535; i++) step(0);
    chk("sat_reach", 32'(bus.taken_cnt), 32'hFFFF);
    step(1);
    chk("sat_hold", 32'(bus.taken_cnt), 32'hFFFF);
    bus.cnt_clr = 1'b1;
    step(1);
    chk("clr_prio", 32'(bus.taken_cnt), 32'd0);
    bus.cnt_clr = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n          = ($urandom_range(63) != 0);
      bus.pipe_stall = ($urandom_range(7) == 0);
      bus.cnt_clr    = ($urandom_range(31) == 0);
      drive($urandom_range(3) != 0, int'($urandom_range(15)), 3'($urandom_range(7)),
            $urandom_range(1) == 1, int'($urandom_range(7)));
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
